// File: rtl/s2mm_burst_ctrl_if.sv
// Control-plane, burst-command and write-completion signals of s2mm_burst_ctrl.
// slave is the sequencer side, master is the control plane / datapath side.
interface s2mm_burst_ctrl_if #(
  parameter int LEN_W = 24
);
  logic             ctrl_start;
  logic [31:0]      ctrl_base_addr;
  logic [LEN_W-1:0] ctrl_len;
  logic             ctrl_abort;
  logic             ctrl_busy;
  logic             ctrl_done;
  logic [1:0]       ctrl_status;
  logic [LEN_W-1:0] ctrl_xfer_cnt;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_addr;
  logic [7:0]       cmd_len;
  logic             wb_done;
  logic [8:0]       wb_beats;
  logic             wb_last;

  modport slave (
    input  ctrl_start, ctrl_base_addr, ctrl_len, ctrl_abort,
    input  cmd_ready, wb_done, wb_beats, wb_last,
    output ctrl_busy, ctrl_done, ctrl_status, ctrl_xfer_cnt,
    output cmd_valid, cmd_addr, cmd_len
  );

  modport master (
    output ctrl_start, ctrl_base_addr, ctrl_len, ctrl_abort,
    output cmd_ready, wb_done, wb_beats, wb_last,
    input  ctrl_busy, ctrl_done, ctrl_status, ctrl_xfer_cnt,
    input  cmd_valid, cmd_addr, cmd_len
  );
endinterface

// File: rtl/s2mm_burst_ctrl.sv
// Splits one S2MM buffer descriptor into AXI write-burst commands and reports completion.
// Define S2MM_BURST_CTRL_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module s2mm_burst_ctrl #(
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = 24
) (
  input logic              clk,
  input logic              rst_n,
  s2mm_burst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_e;

  localparam logic [1:0] StFull  = 2'b00;
  localparam logic [1:0] StEop   = 2'b01;
  localparam logic [1:0] StAbort = 2'b10;
  localparam logic [1:0] StErr   = 2'b11;

  state_e           state_q, state_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [3:0]       outstanding_q, outstanding_d;
  logic             eop_q, eop_d;
  logic             abort_q, abort_d;
  logic [1:0]       status_q, status_d;
  logic [31:0]      cmd_addr_q, cmd_addr_d;
  logic [7:0]       cmd_len_q, cmd_len_d;
  logic [8:0]       burst_q, burst_d;

  logic             cmd_valid;
  logic             handshake;
  logic             active;
  logic             wb_ok;
  logic             eop_ev;
  logic             abort_ev;
  logic             stop;
  logic [8:0]       burst_calc;
  logic [LEN_W-1:0] rem_after;

  assign cmd_valid = (state_q == ISSUE) && (outstanding_q < 4'(MAX_OUTSTANDING));
  assign handshake = cmd_valid && bus.cmd_ready;
  assign active    = (state_q == CALC) || (state_q == ISSUE) || (state_q == DRAIN);
  assign wb_ok     = bus.wb_done && active;
  assign eop_ev    = wb_ok && bus.wb_last;
  // Once eop is recorded, a late abort no longer overrides the end-of-packet status.
  assign abort_ev  = bus.ctrl_abort &&
                     ((state_q == CALC) || (state_q == ISSUE) || ((state_q == DRAIN) && !eop_q));
  assign stop      = eop_q || abort_q || eop_ev || abort_ev;
  assign rem_after = remaining_q - LEN_W'(burst_q);

`ifdef S2MM_BURST_CTRL_4K_SPLIT_EN
  logic [12:0] beats_to_4k;

  // 13-bit difference so that a page-aligned address yields 1024 beats, not 0.
  always_comb begin
    beats_to_4k = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> 2;
    burst_calc  = (remaining_q > LEN_W'(MAX_BURST)) ? 9'(MAX_BURST) : remaining_q[8:0];
    if ({4'b0000, burst_calc} > beats_to_4k) begin
      burst_calc = beats_to_4k[8:0];
    end
  end
`else
  always_comb begin
    burst_calc = (remaining_q > LEN_W'(MAX_BURST)) ? 9'(MAX_BURST) : remaining_q[8:0];
  end
`endif

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    xfer_cnt_d    = xfer_cnt_q;
    outstanding_d = outstanding_q;
    eop_d         = eop_q;
    abort_d       = abort_q;
    status_d      = status_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    burst_d       = burst_q;

    if (handshake && !wb_ok) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!handshake && wb_ok && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
    if (wb_ok) begin
      xfer_cnt_d = xfer_cnt_q + LEN_W'(bus.wb_beats);
    end
    if (eop_ev) begin
      eop_d = 1'b1;
    end
    if (abort_ev) begin
      abort_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.ctrl_start) begin
          cur_addr_d  = {bus.ctrl_base_addr[31:2], 2'b00};
          remaining_d = bus.ctrl_len;
          eop_d       = 1'b0;
          abort_d     = 1'b0;
          if ((bus.ctrl_len == '0) || (bus.ctrl_base_addr[1:0] != 2'b00)) begin
            status_d = StErr;
            state_d  = DONE;
          end else begin
            xfer_cnt_d = '0;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (stop) begin
          state_d = DRAIN;
        end else begin
          burst_d    = burst_calc;
          cmd_addr_d = cur_addr_q;
          cmd_len_d  = 8'(burst_calc - 9'd1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          cur_addr_d  = cur_addr_q + {21'b0, burst_q, 2'b00};
          remaining_d = rem_after;
          state_d     = ((rem_after == '0) || stop) ? DRAIN : CALC;
        end else if (stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_d == 4'd0) begin
          state_d  = DONE;
          status_d = abort_d ? StAbort : (eop_d ? StEop : StFull);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      xfer_cnt_q    <= '0;
      outstanding_q <= '0;
      eop_q         <= 1'b0;
      abort_q       <= 1'b0;
      status_q      <= '0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      burst_q       <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      xfer_cnt_q    <= xfer_cnt_d;
      outstanding_q <= outstanding_d;
      eop_q         <= eop_d;
      abort_q       <= abort_d;
      status_q      <= status_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      burst_q       <= burst_d;
    end
  end

  assign bus.ctrl_busy     = (state_q != IDLE);
  assign bus.ctrl_done     = (state_q == DONE);
  assign bus.ctrl_status   = status_q;
  assign bus.ctrl_xfer_cnt = xfer_cnt_q;
  assign bus.cmd_valid     = cmd_valid;
  assign bus.cmd_addr      = cmd_addr_q;
  assign bus.cmd_len       = cmd_len_q;

endmodule

// File: tb/tb_s2mm_burst_ctrl.sv
// Self-checking bench for s2mm_burst_ctrl: descriptor table plus hand-written
// end-of-packet, outstanding-limit, abort and reset sequences.
module tb_s2mm_burst_ctrl;

  localparam int MAX_BURST = 16;
  localparam int MAX_OUT   = 4;
  localparam int LEN_W     = 24;

`ifdef S2MM_BURST_CTRL_4K_SPLIT_EN
  localparam int Split4kCmds = 2;
`else
  localparam int Split4kCmds = 1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  typedef struct {
    int beats;
    int issued;
  } fly_t;

  typedef struct {
    logic [31:0] base;
    int          len;
    bit          randReady;
    int          expCmds;
    logic [1:0]  expStatus;
    bit          checkXfer;
    int          expXfer;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  s2mm_burst_ctrl_if #(.LEN_W(LEN_W)) bus ();

  s2mm_burst_ctrl #(
    .MAX_BURST      (MAX_BURST),
    .MAX_OUTSTANDING(MAX_OUT),
    .LEN_W          (LEN_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  cmd_t expCmds[$];
  fly_t inflight[$];
  vec_t vecs[8];

  int checks;
  int failures;
  int cyc;
  int handshakes;
  int firstValidCyc;
  int doneCyc;
  int lastWbCyc;
  int startCyc;
  bit autoWb;
  bit doneSeen;
  logic [1:0]       doneStatus;
  logic [LEN_W-1:0] doneXfer;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic observeCmd();
    cmd_t e;
    fly_t f;
    handshakes++;
    if (expCmds.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_unexpected: got addr 0x%0h len %0d, expected no command", bus.cmd_addr, bus.cmd_len);
    end else begin
      e = expCmds.pop_front();
      checkOutput("cmd_addr", bus.cmd_addr, e.addr);
      checkOutput("cmd_len", 32'(bus.cmd_len), 32'(e.len));
      f.beats  = int'(e.len) + 1;
      f.issued = cyc;
      inflight.push_back(f);
    end
  endtask

  // Inputs are set at the falling edge, sampled by the DUT at the next rising edge.
  task automatic stepCycle();
    fly_t f;
    if (autoWb && inflight.size() > 0) begin
      if (cyc - inflight[0].issued >= 3) begin
        f = inflight.pop_front();
        bus.wb_done  = 1'b1;
        bus.wb_beats = 9'(f.beats);
        bus.wb_last  = 1'b0;
      end
    end
    if (bus.wb_done) lastWbCyc = cyc;
    if (bus.cmd_valid && bus.cmd_ready) observeCmd();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.ctrl_start = 1'b0;
    bus.ctrl_abort = 1'b0;
    bus.wb_done    = 1'b0;
    bus.wb_last    = 1'b0;
    bus.wb_beats   = '0;
    if (bus.cmd_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (bus.ctrl_done && !doneSeen) begin
      doneSeen   = 1'b1;
      doneCyc    = cyc;
      doneStatus = bus.ctrl_status;
      doneXfer   = bus.ctrl_xfer_cnt;
    end
  endtask

  task automatic resetTracking();
    handshakes    = 0;
    firstValidCyc = -1;
    doneCyc       = -1;
    lastWbCyc     = -1;
    doneSeen      = 1'b0;
    expCmds.delete();
    inflight.delete();
  endtask

  // Drives the start pulse and queues the bursts a correct splitter must produce.
  task automatic applyStimulus(input logic [31:0] base, input int len);
    logic [31:0] a;
    int rem;
    int b;
    cmd_t c;
    bus.ctrl_start     = 1'b1;
    bus.ctrl_base_addr = base;
    bus.ctrl_len       = LEN_W'(len);
    startCyc           = cyc;
    if (len == 0 || base[1:0] != 2'b00) return;
    a   = base;
    rem = len;
    while (rem > 0) begin
      b = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef S2MM_BURST_CTRL_4K_SPLIT_EN
      if ((4096 - int'(a[11:0])) / 4 < b) b = (4096 - int'(a[11:0])) / 4;
`endif
      c.addr = a;
      c.len  = 8'(b - 1);
      expCmds.push_back(c);
      a   = a + 32'(b * 4);
      rem = rem - b;
    end
  endtask

  task automatic doneTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got no ctrl_done, expected a done pulse within the cycle budget", name);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    autoWb   = 1'b0;
    bus.ctrl_start     = 1'b0;
    bus.ctrl_base_addr = '0;
    bus.ctrl_len       = '0;
    bus.ctrl_abort     = 1'b0;
    bus.cmd_ready      = 1'b0;
    bus.wb_done        = 1'b0;
    bus.wb_beats       = '0;
    bus.wb_last        = 1'b0;
    resetTracking();

    vecs[0] = '{32'h1000_0000,  40, 1'b0,           3, 2'b00, 1'b1,  40};
    vecs[1] = '{32'h0000_0FF0,   8, 1'b0, Split4kCmds, 2'b00, 1'b1,   8};
    vecs[2] = '{32'h0000_0FE8,  20, 1'b1,           2, 2'b00, 1'b1,  20};
    vecs[3] = '{32'h3000_0000, 300, 1'b1,          19, 2'b00, 1'b1, 300};
    vecs[4] = '{32'h2000_0FFC,   1, 1'b0,           1, 2'b00, 1'b1,   1};
    vecs[5] = '{32'h0000_1000,   0, 1'b0,           0, 2'b11, 1'b0,   0};
    vecs[6] = '{32'h0000_1002,   4, 1'b0,           0, 2'b11, 1'b0,   0};
    vecs[7] = '{32'hFFFF_FFC0,  32, 1'b0,           2, 2'b00, 1'b1,  32};

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.ctrl_busy), 0);
    checkOutput("rst_done", 32'(bus.ctrl_done), 0);
    checkOutput("rst_status", 32'(bus.ctrl_status), 0);
    checkOutput("rst_xfer", 32'(bus.ctrl_xfer_cnt), 0);
    checkOutput("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    checkOutput("rst_cmd_addr", bus.cmd_addr, 0);
    checkOutput("rst_cmd_len", 32'(bus.cmd_len), 0);
    rst_n = 1'b1;
    stepCycle();

    // A stray completion while idle must not underflow the outstanding count.
    bus.wb_done  = 1'b1;
    bus.wb_beats = 9'd7;
    stepCycle();

    // Outstanding limit followed by end-of-packet.
    resetTracking();
    autoWb        = 1'b0;
    bus.cmd_ready = 1'b1;
    applyStimulus(32'h4000_0000, 128);
    stepCycle();
    n = 0;
    while (handshakes < 4 && n < 50) begin stepCycle(); n++; end
    repeat (4) stepCycle();
    checkOutput("outstanding_cap_cmds", handshakes, 4);
    checkOutput("outstanding_cap_valid", 32'(bus.cmd_valid), 0);
    bus.wb_done  = 1'b1;
    bus.wb_beats = 9'd16;
    stepCycle();
    checkOutput("valid_after_wb", 32'(bus.cmd_valid), 1);
    repeat (4) stepCycle();
    checkOutput("fifth_cmd_issued", handshakes, 5);
    bus.wb_done  = 1'b1;
    bus.wb_last  = 1'b1;
    bus.wb_beats = 9'd5;
    stepCycle();
    checkOutput("eop_valid_low", 32'(bus.cmd_valid), 0);
    repeat (4) stepCycle();
    checkOutput("eop_no_new_cmds", handshakes, 5);
    for (int i = 0; i < 3; i++) begin
      bus.wb_done  = 1'b1;
      bus.wb_beats = 9'd0;
      stepCycle();
    end
    if (!doneSeen) doneTimeout("eop_done");
    else begin
      checkOutput("eop_status", 32'(doneStatus), 32'h1);
      checkOutput("eop_xfer", 32'(doneXfer), 21);
      checkOutput("eop_done_latency", doneCyc - lastWbCyc, 1);
    end
    stepCycle();

    // Abort while the command is stalled by the datapath.
    resetTracking();
    bus.cmd_ready = 1'b1;
    applyStimulus(32'h5000_0000, 64);
    stepCycle();
    n = 0;
    while (handshakes < 2 && n < 50) begin stepCycle(); n++; end
    bus.cmd_ready = 1'b0;
    repeat (4) stepCycle();
    checkOutput("stall_valid", 32'(bus.cmd_valid), 1);
    checkOutput("stall_cmds", handshakes, 2);
    bus.ctrl_abort = 1'b1;
    stepCycle();
    checkOutput("abort_drops_valid", 32'(bus.cmd_valid), 0);
    for (int i = 0; i < 2; i++) begin
      bus.wb_done  = 1'b1;
      bus.wb_beats = 9'd16;
      stepCycle();
    end
    if (!doneSeen) doneTimeout("abort_done");
    else begin
      checkOutput("abort_status", 32'(doneStatus), 32'h2);
      checkOutput("abort_xfer", 32'(doneXfer), 32);
    end
    bus.cmd_ready = 1'b1;
    stepCycle();

    // Asynchronous reset in the middle of a transfer.
    resetTracking();
    autoWb = 1'b1;
    applyStimulus(32'h6000_0000, 40);
    stepCycle();
    stepCycle();
    checkOutput("pre_reset_valid", 32'(bus.cmd_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(bus.cmd_valid), 0);
    checkOutput("async_rst_busy", 32'(bus.ctrl_busy), 0);
    checkOutput("async_rst_addr", bus.cmd_addr, 0);
    checkOutput("async_rst_done", 32'(bus.ctrl_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    resetTracking();
    stepCycle();

    // Descriptor table.
    for (int i = 0; i < 8; i++) begin
      resetTracking();
      autoWb        = 1'b1;
      bus.cmd_ready = 1'b1;
      applyStimulus(vecs[i].base, vecs[i].len);
      stepCycle();
      checkOutput($sformatf("v%0d_busy_rise", i), 32'(bus.ctrl_busy), 1);
      n = 0;
      while (!doneSeen && n < 3000) begin
        bus.cmd_ready = vecs[i].randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        stepCycle();
        n++;
      end
      if (!doneSeen) doneTimeout($sformatf("v%0d_done", i));
      else begin
        checkOutput($sformatf("v%0d_status", i), 32'(doneStatus), 32'(vecs[i].expStatus));
        checkOutput($sformatf("v%0d_cmd_count", i), handshakes, vecs[i].expCmds);
        checkOutput($sformatf("v%0d_cmds_left", i), expCmds.size(), 0);
        if (vecs[i].checkXfer) begin
          checkOutput($sformatf("v%0d_xfer", i), 32'(doneXfer), vecs[i].expXfer);
        end
        if (vecs[i].expStatus == 2'b11) begin
          checkOutput($sformatf("v%0d_err_no_cmd", i), firstValidCyc, -1);
          checkOutput($sformatf("v%0d_err_latency", i),
                      32'(((doneCyc - startCyc) >= 1) && ((doneCyc - startCyc) <= 2)), 1);
        end else begin
          checkOutput($sformatf("v%0d_start_to_valid", i), firstValidCyc - startCyc, 2);
          checkOutput($sformatf("v%0d_wb_to_done", i), doneCyc - lastWbCyc, 1);
        end
      end
      stepCycle();
      checkOutput($sformatf("v%0d_busy_fall", i), 32'(bus.ctrl_busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
